pet_need_fsm: RTL
=================

Name: pet_need_fsm

Overview:
- Parametrised hunger/health state machine for the virtual-pet design; successor to the fixed 4-state hunger FSM.
- Owns the need level internally: level decays on a timebase tick, rises while feeding, and saturates at both ends.
- Adds a SICK state that only medicine can clear.
- Drives button-enable lines, a state code and a combined display value for the 7-segment driver.

Parameters:
- LEVEL_W, 3: width of the need level.
- LEVEL_MAX, 7: full level and reset value; must be ≤ 9 for display encoding.
- HUNGRY_TH, 4: level ≤ this means hungry.
- STARVE_TH, 1: level ≤ this means starving; must be < HUNGRY_TH.
- DECAY_TICKS, 4: ticks per one-step decay.
- FEED_TICKS, 2: ticks of held feeding per one-step increase.
- SICK_TICKS, 3: consecutive ticks at level 0 in STARVING before SICK.
- DISP_W, 8: width of disp_value.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- tick, input, 1: one-cycle timebase strobe (e.g. 1 Hz).
- btn_food, input, 1: feed button, level-sensitive, pre-synchronised.
- btn_med, input, 1: medicine button, pre-synchronised; rising edge detected internally.
- state_code, output, 3: 0 IDLE, 1 HUNGRY, 2 STARVING, 3 EATING, 4 SICK.
- level, output, LEVEL_W: current need level.
- food_enable, output, 1: feeding allowed indicator.
- med_enable, output, 1: medicine allowed indicator.
- disp_value, output, DISP_W: state_code*10 + level.

Behaviour:
- Reset (async, while reset=0):
  - state = IDLE, level = LEVEL_MAX.
  - All tick counters = 0; med edge register = 0; food_lock = 0.
  - food_enable = 1, med_enable = 0, disp_value = LEVEL_MAX.
  - Takes effect immediately, including mid-EATING or in SICK.
- General:
  - All registers update on posedge clk.
  - Transitions use the current (registered) level, so the state reacts one cycle after the level crosses a threshold.
  - Outputs are registered and decoded from the next state, so state_code, enables and disp_value change on the same edge as the state register.
- Decay:
  - decay_cnt counts ticks when state ≠ EATING and is paused (not cleared) in EATING.
  - On the tick where decay_cnt = DECAY_TICKS-1: decay_cnt ← 0 and level ← level-1, saturating at 0.
- Feeding:
  - feed_cnt is cleared on entry to EATING.
  - In EATING, each tick increments feed_cnt; at FEED_TICKS-1 it wraps and level ← level+1, saturating at LEVEL_MAX.
  - A tick on the EATING entry edge is counted.
- med_rise = btn_med & ~btn_med_q, where btn_med_q is btn_med registered.
- food_lock:
  - Set when EATING exits with btn_food still high.
  - Cleared when btn_food = 0.
  - Feeding entry requires btn_food = 1 and food_lock = 0.
- Transitions, in priority order within each state:
  - IDLE: level ≤ STARVE_TH → STARVING; level ≤ HUNGRY_TH → HUNGRY; feed entry → EATING.
  - HUNGRY: level ≤ STARVE_TH → STARVING; feed entry → EATING.
  - STARVING: feed entry → EATING; sick_cnt reaches SICK_TICKS → SICK.
    - sick_cnt increments on tick while level = 0.
    - sick_cnt clears when level ≠ 0 or on leaving STARVING.
  - EATING: exits when btn_food = 0 or level = LEVEL_MAX. Exit target by level:
    - level > HUNGRY_TH → IDLE.
    - level > STARVE_TH → HUNGRY.
    - otherwise → STARVING.
  - SICK: med_rise → STARVING with sick_cnt cleared. btn_food is ignored; decay continues, so level stays 0.
- Enables:
  - food_enable = 1 in IDLE, HUNGRY, STARVING; 0 in EATING and SICK.
  - med_enable = 1 only in SICK.
- Boundaries:
  - Decay and feeding never wrap.
  - Tick and feed entry on the same edge: entry wins and no decay is applied on that edge.
  - btn_med held high gives one edge only.
  - Illegal state codes 5–7 → IDLE on the next edge.

Test Plan (default parameters, tick asserted every cycle unless noted):
- Reset: pulse reset low → state_code 0, level 7, disp_value 7, food_enable 1, med_enable 0.
- Decay path, no buttons:
  - After 12 ticks → level 4, then state HUNGRY one cycle later, disp_value 14.
  - After 24 ticks → level 1, STARVING, disp_value 21.
- Sickness: continue from starving.
  - After 28 ticks → level 0.
  - 3 more ticks → SICK, disp_value 40, food_enable 0, med_enable 1.
  - Holding btn_food in SICK keeps state 4.
- Medicine: in SICK, hold btn_med high for 5 cycles → exactly one transition to STARVING, disp_value 20, sick_cnt restarts.
- Feeding: at HUNGRY level 4, hold btn_food.
  - EATING (code 3); level reaches 7 after 6 ticks.
  - Exits to IDLE, disp_value 7.
  - Keep holding: no re-entry. Release then press → re-enters EATING, then exits to IDLE (at max).
  - Early release at level 5 → IDLE.
- Async reset mid-EATING at level 5 → outputs return to reset values without waiting for a clk edge; decay resumes from decay_cnt 0.

Source files
------------

// File: rtl/pet_need_fsm.sv
// Hunger/health state machine for the virtual pet: owns the need level, decays it on
// timebase ticks, raises it while feeding, and decodes state, enables and display value.
module pet_need_fsm #(
    parameter int LEVEL_W     = 3,
    parameter int LEVEL_MAX   = 7,
    parameter int HUNGRY_TH   = 4,
    parameter int STARVE_TH   = 1,
    parameter int DECAY_TICKS = 4,
    parameter int FEED_TICKS  = 2,
    parameter int SICK_TICKS  = 3,
    parameter int DISP_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               btn_food,
    input  logic               btn_med,
    output logic [2:0]         state_code,
    output logic [LEVEL_W-1:0] level,
    output logic               food_enable,
    output logic               med_enable,
    output logic [DISP_W-1:0]  disp_value
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HUNGRY   = 3'd1,
        S_STARVING = 3'd2,
        S_EATING   = 3'd3,
        S_SICK     = 3'd4
    } state_t;

    localparam int DC_W = $clog2(DECAY_TICKS + 1);
    localparam int FC_W = $clog2(FEED_TICKS + 1);
    localparam int SC_W = $clog2(SICK_TICKS + 1);

    localparam logic [LEVEL_W-1:0] LVL_MAX    = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_HUNGRY = LEVEL_W'(HUNGRY_TH);
    localparam logic [LEVEL_W-1:0] LVL_STARVE = LEVEL_W'(STARVE_TH);
    localparam logic [DC_W-1:0]    DECAY_LAST = DC_W'(DECAY_TICKS - 1);
    localparam logic [FC_W-1:0]    FEED_LAST  = FC_W'(FEED_TICKS - 1);
    localparam logic [SC_W-1:0]    SICK_LAST  = SC_W'(SICK_TICKS - 1);

    state_t              state, state_nxt;
    logic [LEVEL_W-1:0]  level_nxt;
    logic [DC_W-1:0]     decay_cnt, decay_nxt;
    logic [FC_W-1:0]     feed_cnt, feed_nxt, feed_base;
    logic [SC_W-1:0]     sick_cnt, sick_nxt;
    logic                btn_med_q;
    logic                food_lock, lock_nxt;
    logic                feed_ok, med_rise, entering;
    logic                food_en_nxt, med_en_nxt;
    logic [DISP_W-1:0]   disp_nxt;

    function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] lv);
        return (lv >= LVL_MAX) ? LVL_MAX : lv + 1'b1;
    endfunction

    function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] lv);
        return (lv == '0) ? '0 : lv - 1'b1;
    endfunction

    // Next-state decode from the registered level and counters
    always_comb begin
        feed_ok   = btn_food & ~food_lock;
        med_rise  = btn_med & ~btn_med_q;
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: begin
                if (level <= LVL_STARVE)      state_nxt = S_STARVING;
                else if (level <= LVL_HUNGRY) state_nxt = S_HUNGRY;
                else if (feed_ok)             state_nxt = S_EATING;
                else                          state_nxt = S_IDLE;
            end
            S_HUNGRY: begin
                if (level <= LVL_STARVE) state_nxt = S_STARVING;
                else if (feed_ok)        state_nxt = S_EATING;
                else                     state_nxt = S_HUNGRY;
            end
            S_STARVING: begin
                if (feed_ok)                                             state_nxt = S_EATING;
                else if (tick && level == '0 && sick_cnt == SICK_LAST)   state_nxt = S_SICK;
                else                                                     state_nxt = S_STARVING;
            end
            S_EATING: begin
                if (!btn_food || level == LVL_MAX) begin
                    if (level > LVL_HUNGRY)      state_nxt = S_IDLE;
                    else if (level > LVL_STARVE) state_nxt = S_HUNGRY;
                    else                         state_nxt = S_STARVING;
                end else begin
                    state_nxt = S_EATING;
                end
            end
            S_SICK:  state_nxt = med_rise ? S_STARVING : S_SICK;
            default: state_nxt = S_IDLE;
        endcase

        // Feeding takes the tick on the entry edge, so decay sees nothing then
        entering  = (state != S_EATING) && (state_nxt == S_EATING);
        level_nxt = level;
        decay_nxt = decay_cnt;
        feed_nxt  = feed_cnt;
        feed_base = entering ? '0 : feed_cnt;
        if (state == S_EATING || entering) begin
            feed_nxt = feed_base;
            if (tick) begin
                if (feed_base == FEED_LAST) begin
                    feed_nxt  = '0;
                    level_nxt = sat_inc(level);
                end else begin
                    feed_nxt = feed_base + 1'b1;
                end
            end
        end else if (tick) begin
            if (decay_cnt == DECAY_LAST) begin
                decay_nxt = '0;
                level_nxt = sat_dec(level);
            end else begin
                decay_nxt = decay_cnt + 1'b1;
            end
        end

        sick_nxt = '0;
        if (state == S_STARVING && state_nxt == S_STARVING && level == '0)
            sick_nxt = tick ? sick_cnt + 1'b1 : sick_cnt;

        lock_nxt = food_lock;
        if (!btn_food)
            lock_nxt = 1'b0;
        else if (state == S_EATING && state_nxt != S_EATING)
            lock_nxt = 1'b1;

        food_en_nxt = (state_nxt == S_IDLE) || (state_nxt == S_HUNGRY) || (state_nxt == S_STARVING);
        med_en_nxt  = (state_nxt == S_SICK);
        disp_nxt    = DISP_W'(state_nxt) * DISP_W'(10) + DISP_W'(level_nxt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            level       <= LVL_MAX;
            decay_cnt   <= '0;
            feed_cnt    <= '0;
            sick_cnt    <= '0;
            btn_med_q   <= 1'b0;
            food_lock   <= 1'b0;
            food_enable <= 1'b1;
            med_enable  <= 1'b0;
            disp_value  <= DISP_W'(LEVEL_MAX);
        end else begin
            state       <= state_nxt;
            level       <= level_nxt;
            decay_cnt   <= decay_nxt;
            feed_cnt    <= feed_nxt;
            sick_cnt    <= sick_nxt;
            btn_med_q   <= btn_med;
            food_lock   <= lock_nxt;
            food_enable <= food_en_nxt;
            med_enable  <= med_en_nxt;
            disp_value  <= disp_nxt;
        end
    end

    assign state_code = state;

endmodule
